// File: rtl/bp_me_mem_cmd_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bp_me_mem_cmd_arbiter_pkg
// Description : Shared types and constants for the memory-command arbiter:
//               BedRock memory message types, the mask of payload-carrying
//               types, the arbiter FSM states and the beat-count helper.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package bp_me_mem_cmd_arbiter_pkg;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3,
    e_mem_msg_pre   = 4'd4
  } bp_bedrock_mem_type_e;

  // One bit per message type; set bits carry data beats (wr and uc_wr).
  localparam logic [15:0] mem_cmd_payload_mask_gp = 16'b0000_0000_0000_1010;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_hdr  = 2'd1,
    e_data = 2'd2
  } bp_me_mem_cmd_arb_state_e;

  // Number of data beats minus one for a message of 2^size bytes.
  // A 9-bit width holds 128 bytes; sub-beat messages still take one beat.
  function automatic logic [8:0] beats_minus_one(input logic [2:0]  size,
                                                 input int unsigned lg_beat_bytes);
    logic [8:0] num_bytes;
    logic [8:0] num_beats;
    num_bytes = 9'd1 << size;
    num_beats = num_bytes >> lg_beat_bytes;
    return (num_beats == 9'd0) ? 9'd0 : (num_beats - 9'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_me_mem_cmd_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bp_me_mem_cmd_arbiter_if
// Description : Bundle of the requester-side and memory-side command channels.
//               slave  : view of the arbiter (consumes requests, drives mem side)
//               master : view of the surrounding logic (requesters + memory)
// Ports       : req_* per-requester header/data channels, mem_* shared channel,
//               grant_id_o current owner for response routing.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface bp_me_mem_cmd_arbiter_if #(
  parameter int num_req_p     = 2,
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64
);
  localparam int c_lg_req = $clog2(num_req_p);

  logic [num_req_p-1:0]                     req_header_v_i;
  logic [num_req_p-1:0]                     req_header_ready_o;
  logic [num_req_p-1:0][3:0]                req_msg_type_i;
  logic [num_req_p-1:0][2:0]                req_size_i;
  logic [num_req_p-1:0][paddr_width_p-1:0]  req_addr_i;
  logic [num_req_p-1:0][data_width_p-1:0]   req_data_i;
  logic [num_req_p-1:0]                     req_data_v_i;
  logic [num_req_p-1:0]                     req_data_ready_o;

  logic                                     mem_header_v_o;
  logic [3:0]                               mem_msg_type_o;
  logic [2:0]                               mem_size_o;
  logic [paddr_width_p-1:0]                 mem_addr_o;
  logic                                     mem_header_ready_i;
  logic [data_width_p-1:0]                  mem_data_o;
  logic                                     mem_data_v_o;
  logic                                     mem_data_ready_i;

  logic [c_lg_req-1:0]                      grant_id_o;

  modport slave (
    input  req_header_v_i, req_msg_type_i, req_size_i, req_addr_i,
           req_data_i, req_data_v_i, mem_header_ready_i, mem_data_ready_i,
    output req_header_ready_o, req_data_ready_o, mem_header_v_o,
           mem_msg_type_o, mem_size_o, mem_addr_o, mem_data_o, mem_data_v_o,
           grant_id_o
  );

  modport master (
    output req_header_v_i, req_msg_type_i, req_size_i, req_addr_i,
           req_data_i, req_data_v_i, mem_header_ready_i, mem_data_ready_i,
    input  req_header_ready_o, req_data_ready_o, mem_header_v_o,
           mem_msg_type_o, mem_size_o, mem_addr_o, mem_data_o, mem_data_v_o,
           grant_id_o
  );

endinterface
`default_nettype wire

// File: rtl/bp_me_rr_picker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bp_me_rr_picker
// Description : Combinational round-robin picker. Returns the first set bit of
//               i_v at or above i_ptr, wrapping past NUM_REQ-1 to 0.
// Ports       : i_v valid vector, i_ptr priority pointer,
//               o_grant winner index, o_any_v any bit of i_v set.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module bp_me_rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_v,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [$clog2(NUM_REQ)-1:0] o_grant,
  output logic                       o_any_v
);
  localparam int c_lg = $clog2(NUM_REQ);

  logic [c_lg:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Candidate i positions above the pointer, folded back into range.
      w_idx = {1'b0, i_ptr} + (c_lg+1)'(i);
      if (w_idx >= (c_lg+1)'(NUM_REQ)) begin
        w_idx = w_idx - (c_lg+1)'(NUM_REQ);
      end
      if (!w_found && i_v[w_idx[c_lg-1:0]]) begin
        o_grant = w_idx[c_lg-1:0];
        w_found = 1'b1;
      end
    end
  end

  assign o_any_v = |i_v;

endmodule
`default_nettype wire

// File: rtl/bp_me_mem_cmd_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bp_me_mem_cmd_arbiter
// Description : Round-robin arbiter sharing one memory-command channel among
//               num_req_p requesters. The grant is held from the header beat
//               through the last data beat of write / uncached-write messages.
//               Header and data are passed through combinationally.
// Ports       : clk_i clock, reset_n_i async active-low reset,
//               bus (slave modport) requester and memory-side channels.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module bp_me_mem_cmd_arbiter
  import bp_me_mem_cmd_arbiter_pkg::*;
#(
  parameter int num_req_p     = 2,
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bp_me_mem_cmd_arbiter_if.slave bus
);
  localparam int          c_lg_req         = $clog2(num_req_p);
  localparam int unsigned c_lg_beat_bytes  = $clog2(data_width_p/8);
  localparam logic [c_lg_req-1:0] c_last_req = c_lg_req'(num_req_p-1);

  bp_me_mem_cmd_arb_state_e r_state, w_state_next;
  logic [c_lg_req-1:0]      r_rr_ptr, w_rr_ptr_next;
  logic [c_lg_req-1:0]      r_grant_id, w_grant_id_next;
  logic [8:0]               r_beat_cnt, w_beat_cnt_next;

  logic [c_lg_req-1:0]      w_pick_id;
  logic [c_lg_req-1:0]      w_grant_inc;
  logic                     w_any_v;
  logic                     w_is_payload;
  logic                     w_hdr_hs;
  logic                     w_data_hs;
  logic [num_req_p-1:0]     w_hdr_ready;
  logic [num_req_p-1:0]     w_data_ready;

  bp_me_rr_picker #(
    .NUM_REQ (num_req_p)
  ) u_picker (
    .i_v     (bus.req_header_v_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_id),
    .o_any_v (w_any_v)
  );

  // Output muxes follow the current owner at all times; only valids and
  // readies are qualified by state, so reset leaves requester 0 on the bus.
  assign bus.mem_msg_type_o = bus.req_msg_type_i[r_grant_id];
  assign bus.mem_size_o     = bus.req_size_i[r_grant_id];
  assign bus.mem_addr_o     = bus.req_addr_i[r_grant_id];
  assign bus.mem_data_o     = bus.req_data_i[r_grant_id];
  assign bus.grant_id_o     = r_grant_id;

  assign bus.mem_header_v_o = (r_state == e_hdr)  && bus.req_header_v_i[r_grant_id];
  assign bus.mem_data_v_o   = (r_state == e_data) && bus.req_data_v_i[r_grant_id];
  assign bus.req_header_ready_o = w_hdr_ready;
  assign bus.req_data_ready_o   = w_data_ready;

  assign w_hdr_hs     = bus.mem_header_v_o && bus.mem_header_ready_i;
  assign w_data_hs    = bus.mem_data_v_o   && bus.mem_data_ready_i;
  assign w_is_payload = mem_cmd_payload_mask_gp[bus.req_msg_type_i[r_grant_id]];
  assign w_grant_inc  = (r_grant_id == c_last_req) ? '0 : (r_grant_id + c_lg_req'(1));

  always_comb begin
    w_hdr_ready  = '0;
    w_data_ready = '0;
    if (r_state == e_hdr) begin
      w_hdr_ready[r_grant_id] = bus.mem_header_ready_i;
    end
    if (r_state == e_data) begin
      w_data_ready[r_grant_id] = bus.mem_data_ready_i;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_rr_ptr_next   = r_rr_ptr;
    w_grant_id_next = r_grant_id;
    w_beat_cnt_next = r_beat_cnt;
    case (r_state)
      e_idle: begin
        if (w_any_v) begin
          w_grant_id_next = w_pick_id;
          w_state_next    = e_hdr;
        end
      end
      e_hdr: begin
        if (w_hdr_hs) begin
          if (w_is_payload) begin
            w_beat_cnt_next = beats_minus_one(bus.req_size_i[r_grant_id], c_lg_beat_bytes);
            w_state_next    = e_data;
          end else begin
            w_rr_ptr_next = w_grant_inc;
            w_state_next  = e_idle;
          end
        end
      end
      e_data: begin
        if (w_data_hs) begin
          if (r_beat_cnt == 9'd0) begin
            w_rr_ptr_next = w_grant_inc;
            w_state_next  = e_idle;
          end else begin
            w_beat_cnt_next = r_beat_cnt - 9'd1;
          end
        end
      end
      default: w_state_next = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= e_idle;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_grant_id <= w_grant_id_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_bp_me_mem_cmd_arbiter
// Description : Self-checking bench for bp_me_mem_cmd_arbiter. Requesters are
//               message queues; a transaction-level model predicts the owner
//               of the channel, the passthrough values and the ready routing.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bp_me_mem_cmd_arbiter;
  localparam int N  = 2;
  localparam int AW = 40;
  localparam int DW = 64;

  typedef struct {
    logic [3:0]    t;
    logic [2:0]    sz;
    logic [AW-1:0] addr;
    int            id;
  } msg_t;

  logic clk_i;
  logic reset_n_i;

  bp_me_mem_cmd_arbiter_if #(.num_req_p(N), .paddr_width_p(AW), .data_width_p(DW)) bus ();

  bp_me_mem_cmd_arbiter #(.num_req_p(N), .paddr_width_p(AW), .data_width_p(DW)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // requester side
  msg_t q [N][$];
  bit   hdr_sent [N];
  bit   hv_hold  [N];
  bit   dv_hold  [N];
  int   beat_idx [N];
  int   next_id = 0;

  // stimulus knobs (percent probabilities)
  int hv_pct = 100, dv_pct = 100, mh_pct = 100, md_pct = 100;
  int bp_at = -1, bp_len = 0;
  bit bp_now = 1'b0;

  // transaction-level model of channel ownership
  int owner = -1;
  bit o_hdr_done = 1'b0;
  int o_beats_left = 0;
  int rr_next = 0;
  int done_cnt = 0;
  int data_hs_cnt = 0;
  int grant_log [$];

  int tests = 0;
  int fails = 0;

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  function automatic bit has_payload(input logic [3:0] t);
    return (t == 4'd1) || (t == 4'd3);
  endfunction

  function automatic int num_beats(input logic [2:0] sz);
    int b;
    b = (1 << sz) / (DW / 8);
    return (b < 1) ? 1 : b;
  endfunction

  function automatic logic [DW-1:0] beat_data(input int id, input int b);
    logic [31:0] hi;
    hi = 32'(id) * 32'h9E37_79B1;
    return {hi, 32'(b) ^ 32'h5A5A_0000};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add(input int r, input logic [3:0] t, input logic [2:0] sz);
    msg_t m;
    m.t    = t;
    m.sz   = sz;
    m.addr = {8'($urandom()), 32'($urandom())};
    m.id   = next_id;
    next_id++;
    q[r].push_back(m);
  endtask

  task automatic pop_msg(input int r);
    void'(q[r].pop_front());
    hdr_sent[r] = 1'b0;
    hv_hold[r]  = 1'b0;
    dv_hold[r]  = 1'b0;
    beat_idx[r] = 0;
  endtask

  task automatic clear_all();
    for (int r = 0; r < N; r++) begin
      q[r].delete();
      hdr_sent[r] = 1'b0;
      hv_hold[r]  = 1'b0;
      dv_hold[r]  = 1'b0;
      beat_idx[r] = 0;
    end
    owner = -1;
    o_hdr_done = 1'b0;
    rr_next = 0;
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      bus.req_header_v_i[r] = 1'b0;
      bus.req_data_v_i[r]   = 1'b0;
      if (q[r].size() > 0) begin
        msg_t m;
        m = q[r][0];
        bus.req_msg_type_i[r] = m.t;
        bus.req_size_i[r]     = m.sz;
        bus.req_addr_i[r]     = m.addr;
        if (!hdr_sent[r] && (hv_hold[r] || pct(hv_pct))) begin
          bus.req_header_v_i[r] = 1'b1;
          hv_hold[r] = 1'b1;
        end
        if (has_payload(m.t) && beat_idx[r] < num_beats(m.sz)) begin
          bus.req_data_i[r] = beat_data(m.id, beat_idx[r]);
          if (dv_hold[r] || pct(dv_pct)) begin
            bus.req_data_v_i[r] = 1'b1;
            dv_hold[r] = 1'b1;
          end
        end
      end
    end
    bus.mem_header_ready_i = pct(mh_pct);
    bus.mem_data_ready_i   = pct(md_pct);
    bp_now = 1'b0;
    if (bp_len > 0 && data_hs_cnt == bp_at) begin
      bus.mem_data_ready_i = 1'b0;
      bp_len--;
      bp_now = 1'b1;
    end
  endtask

  task automatic check_update();
    logic [N-1:0] exp_hr, exp_dr;
    logic         exp_hv, exp_dv;
    msg_t         m;
    exp_hr = '0; exp_dr = '0; exp_hv = 1'b0; exp_dv = 1'b0;
    m = '{t: 4'd0, sz: 3'd0, addr: '0, id: 0};
    if (owner >= 0) begin
      m = q[owner][0];
      chk("grant_id", 64'(bus.grant_id_o), 64'(owner));
      if (!o_hdr_done) begin
        exp_hv = bus.req_header_v_i[owner];
        exp_hr[owner] = bus.mem_header_ready_i;
        if (exp_hv) begin
          chk("mem_msg_type", 64'(bus.mem_msg_type_o), 64'(m.t));
          chk("mem_size", 64'(bus.mem_size_o), 64'(m.sz));
          chk("mem_addr", 64'(bus.mem_addr_o), 64'(m.addr));
        end
      end else begin
        exp_dv = bus.req_data_v_i[owner];
        exp_dr[owner] = bus.mem_data_ready_i;
        if (exp_dv) begin
          chk("mem_data", bus.mem_data_o, beat_data(m.id, num_beats(m.sz) - o_beats_left));
        end
        if (bp_now) begin
          chk("bp_hold_data", bus.mem_data_o, beat_data(m.id, 3));
        end
      end
    end
    chk("mem_header_v", 64'(bus.mem_header_v_o), 64'(exp_hv));
    chk("mem_data_v", 64'(bus.mem_data_v_o), 64'(exp_dv));
    chk("req_header_ready", 64'(bus.req_header_ready_o), 64'(exp_hr));
    chk("req_data_ready", 64'(bus.req_data_ready_o), 64'(exp_dr));

    // model: who owns the channel next
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr_next + k) % N;
        if (bus.req_header_v_i[c]) begin
          owner = c;
          o_hdr_done = 1'b0;
          grant_log.push_back(c);
          break;
        end
      end
    end else if (!o_hdr_done) begin
      if (exp_hv && bus.mem_header_ready_i) begin
        if (has_payload(m.t)) begin
          o_hdr_done = 1'b1;
          o_beats_left = num_beats(m.sz);
        end else begin
          rr_next = (owner + 1) % N;
          owner = -1;
          done_cnt++;
        end
      end
    end else if (exp_dv && bus.mem_data_ready_i) begin
      data_hs_cnt++;
      o_beats_left--;
      if (o_beats_left == 0) begin
        rr_next = (owner + 1) % N;
        owner = -1;
        done_cnt++;
      end
    end

    // requesters react to the readies the DUT actually offered
    for (int r = 0; r < N; r++) begin
      if (q[r].size() > 0) begin
        if (bus.req_header_v_i[r] && bus.req_header_ready_o[r]) begin
          hdr_sent[r] = 1'b1;
          hv_hold[r]  = 1'b0;
          if (!has_payload(q[r][0].t)) pop_msg(r);
        end
        if (q[r].size() > 0 && bus.req_data_v_i[r] && bus.req_data_ready_o[r]) begin
          beat_idx[r]++;
          dv_hold[r] = 1'b0;
          if (beat_idx[r] == num_beats(q[r][0].sz)) pop_msg(r);
        end
      end
    end
  endtask

  task automatic step();
    drive();
    #1;
    check_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_all(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while ((q[0].size() > 0 || q[1].size() > 0 || owner >= 0) && cyc < budget) begin
      step();
      cyc++;
    end
    chk({tag, "_drained"}, 64'(q[0].size() == 0 && q[1].size() == 0 && owner < 0), 64'd1);
  endtask

  initial begin
    int base_done, base_hs, cyc;

    // reset state, with requests pending to prove readies are gated
    reset_n_i = 1'b0;
    bus.req_header_v_i = '1;
    bus.req_data_v_i   = '1;
    bus.req_msg_type_i = '{4'd1, 4'd1};
    bus.req_size_i     = '{3'd6, 3'd6};
    bus.req_addr_i     = '{40'hBB_BBBB_BBBB, 40'hAA_AAAA_AAAA};
    bus.req_data_i     = '{64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000};
    bus.mem_header_ready_i = 1'b1;
    bus.mem_data_ready_i   = 1'b1;
    clear_all();
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_mem_header_v", 64'(bus.mem_header_v_o), 64'd0);
    chk("rst_mem_data_v", 64'(bus.mem_data_v_o), 64'd0);
    chk("rst_hdr_ready", 64'(bus.req_header_ready_o), 64'd0);
    chk("rst_data_ready", 64'(bus.req_data_ready_o), 64'd0);
    chk("rst_grant", 64'(bus.grant_id_o), 64'd0);
    chk("rst_addr_req0", 64'(bus.mem_addr_o), 64'h00AA_AAAA_AAAA);
    chk("rst_data_req0", bus.mem_data_o, 64'h0);
    bus.req_header_v_i = '0;
    bus.req_data_v_i   = '0;
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;

    // single rd from req1
    grant_log.delete();
    add(1, 4'd0, 3'd6);
    run_all("s1", 50);
    chk("s1_grants", 64'(grant_log.size()), 64'd1);
    if (grant_log.size() > 0) chk("s1_grant_id", 64'(grant_log[0]), 64'd1);

    // wr 64B from req0 against concurrent rd from req1
    grant_log.delete();
    base_hs = data_hs_cnt;
    add(0, 4'd1, 3'd6);
    add(1, 4'd0, 3'd3);
    run_all("s2", 100);
    chk("s2_beats", 64'(data_hs_cnt - base_hs), 64'd8);
    chk("s2_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      chk("s2_first", 64'(grant_log[0]), 64'd0);
      chk("s2_second", 64'(grant_log[1]), 64'd1);
    end

    // both hold rd continuously: strict alternation
    grant_log.delete();
    for (int i = 0; i < 5; i++) begin
      add(0, 4'd0, 3'($urandom_range(7)));
      add(1, 4'd2, 3'($urandom_range(7)));
    end
    run_all("s3", 200);
    chk("s3_grants", 64'(grant_log.size()), 64'd10);
    for (int i = 1; i < grant_log.size(); i++) begin
      chk("s3_alternate", 64'(grant_log[i] != grant_log[i-1]), 64'd1);
    end

    // uc_wr of one byte: one beat
    base_hs = data_hs_cnt;
    add(0, 4'd3, 3'd0);
    run_all("s4", 50);
    chk("s4_beats", 64'(data_hs_cnt - base_hs), 64'd1);

    // downstream stall of 5 cycles during beat 3 of a burst
    base_hs = data_hs_cnt;
    bp_at = base_hs + 3;
    bp_len = 5;
    add(1, 4'd1, 3'd6);
    run_all("s5", 100);
    chk("s5_beats", 64'(data_hs_cnt - base_hs), 64'd8);
    chk("s5_stall_used", 64'(bp_len), 64'd0);
    bp_at = -1;

    // async reset mid-burst, with rr pointer left pointing at req1
    add(0, 4'd0, 3'd6);
    run_all("s6a", 50);
    base_hs = data_hs_cnt;
    add(0, 4'd1, 3'd6);
    cyc = 0;
    while (data_hs_cnt < base_hs + 2 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("s6_reach_beat3", 64'(data_hs_cnt - base_hs), 64'd2);
    drive();
    #1;
    reset_n_i = 1'b0;
    #1;
    chk("s6_rst_header_v", 64'(bus.mem_header_v_o), 64'd0);
    chk("s6_rst_data_v", 64'(bus.mem_data_v_o), 64'd0);
    chk("s6_rst_hdr_ready", 64'(bus.req_header_ready_o), 64'd0);
    chk("s6_rst_data_ready", 64'(bus.req_data_ready_o), 64'd0);
    clear_all();
    drive();
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    grant_log.delete();
    add(1, 4'd0, 3'd6);
    add(0, 4'd4, 3'd2);
    run_all("s6b", 50);
    chk("s6_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      chk("s6_rr_reset", 64'(grant_log[0]), 64'd0);
      chk("s6_req1_after", 64'(grant_log[1]), 64'd1);
    end

    // randomized traffic with random valids and backpressure
    hv_pct = 60; dv_pct = 50; mh_pct = 70; md_pct = 70;
    base_done = done_cnt;
    for (int i = 0; i < 30; i++) begin
      add(0, 4'($urandom_range(4)), 3'($urandom_range(7)));
      add(1, 4'($urandom_range(4)), 3'($urandom_range(7)));
    end
    run_all("rand", 20000);
    chk("rand_msgs", 64'(done_cnt - base_done), 64'd60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bp_me_mem_cmd_arbiter.md
# bp_me_mem_cmd_arbiter

- Shares one memory-command channel between `num_req_p` requesters, e.g. the CCE and the I/O master.
- Round-robin arbitration, one winner per message.
- The grant stays locked through the header beat and every data beat of a payload-carrying message.
- Sits between the requesters and the memory-side wormhole adapter.
- Payload-carrying types are fixed as write and uncached write, matching the ME package's command payload mask.

## Interface
Parameters:
- `num_req_p`, 2: number of requesters (2..8).
- `paddr_width_p`, 40: address width.
- `data_width_p`, 64: data beat width in bits (64..512, power of two).

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `req_header_v_i` in `num_req_p`: header valid, per requester.
- `req_header_ready_o` out `num_req_p`: header ready, per requester.
- `req_msg_type_i` in `num_req_p`x4: message type (`bp_bedrock_mem_type_e`).
- `req_size_i` in `num_req_p`x3: log2 bytes (0=1B .. 6=64B, 7=128B).
- `req_addr_i` in `num_req_p`x`paddr_width_p`: address.
- `req_data_i` in `num_req_p`x`data_width_p`: data beat.
- `req_data_v_i` in `num_req_p`: data valid.
- `req_data_ready_o` out `num_req_p`: data ready.
- `mem_header_v_o` out 1: output header valid.
- `mem_msg_type_o` out 4: output message type.
- `mem_size_o` out 3: output size.
- `mem_addr_o` out `paddr_width_p`: output address.
- `mem_header_ready_i` in 1: downstream header ready.
- `mem_data_o` out `data_width_p`: output data beat.
- `mem_data_v_o` out 1: output data valid.
- `mem_data_ready_i` in 1: downstream data ready.
- `grant_id_o` out `lg(num_req_p)`: current owner; used by the response router to tag the source.

## Operation
- Protocol: ready-valid-and. A handshake is `v & ready` in the same cycle. Requesters hold valid and fields stable until handshake.
- Payload test: `msg_type` is e_mem_msg_wr (1) or e_mem_msg_uc_wr (3). All other types are header-only: rd=0, uc_rd=2, pre=4.
- Beat count = max(1, 2^size / (`data_width_p`/8)). Compute in a 9-bit width; no overflow for size ≤ 7.
- FSM states: e_idle, e_hdr, e_data.
- e_idle:
  - If any `req_header_v_i` is set, pick a winner. The winner is the first valid at or after `rr_ptr`, scanning upward with wrap.
  - Register the winner into `grant_id_r` and go to e_hdr.
  - All readies are 0 in this state.
- e_hdr:
  - `mem_header_v_o` = `req_header_v_i[grant_id_r]`, and the header fields mux from `grant_id_r`.
  - `req_header_ready_o[grant_id_r]` = `mem_header_ready_i`; every other requester's ready is 0.
  - On handshake with a payload type: load `beat_cnt` = beats-1 and go to e_data.
  - On handshake with a header-only type: set `rr_ptr` = `grant_id_r`+1 (mod `num_req_p`) and go to e_idle.
- e_data:
  - `mem_data_v_o` / `mem_data_o` come from the granted requester.
  - The data ready routes only to the granted requester.
  - On each data handshake: if `beat_cnt` == 0, advance `rr_ptr` as above and go to e_idle; else decrement `beat_cnt`.
- Non-granted requesters never see ready, even if their valid is held for many cycles.
- `grant_id_o` = `grant_id_r` at all times. It is meaningful only in e_hdr and e_data.

## Timing
- Reset values:
  - state = e_idle, `rr_ptr` = 0, `grant_id_r` = 0, `beat_cnt` = 0.
  - Every `_v_o` and `_ready_o` is 0.
  - Data and header outputs are don't-care but driven from requester 0.
- Arbitration latency: 1 cycle, from header valid in e_idle to `mem_header_v_o` in e_hdr.
- Header and data paths are combinational pass-through in e_hdr and e_data; there is no storage of payload.
- Throughput:
  - Header-only message: 2 cycles minimum (e_idle + e_hdr).
  - N-beat write: N+2 cycles minimum.
- Data valid may arrive before or after the header handshake. Beats are accepted only in e_data.
- Async reset mid-message drops the message: state returns to e_idle and all readies fall immediately. Upstream and downstream must be reset together.
- Simultaneous valids are resolved by `rr_ptr` alone. A new valid appearing while in e_hdr or e_data does not change the grant.
- `rr_ptr` wraps from `num_req_p`-1 to 0.

## Structure
- Shared package constants:
  - Payload mask `mem_cmd_payload_mask_gp`, using the `bp_bedrock_mem_type_e` encodings.
  - FSM enum `bp_me_mem_cmd_arb_state_e`.
- Sub-module `bp_me_rr_picker` (combinational): inputs valid vector and `rr_ptr`; outputs winner index and any-valid. It is reusable for the response-side router.

## Test plan
- Single rd at size 6 from req1, downstream always ready:
  - `mem_header_v_o` rises 1 cycle after request valid.
  - `grant_id_o` = 1, no data beats.
  - Back to e_idle; `rr_ptr` = 0 (wraps, 2 requesters).
- wr at size 6 (64B), `data_width_p`=64, from req0:
  - Exactly 8 data beats pass in order.
  - req1's concurrent valid header is held off until the 8th beat.
  - req1 is then granted.
- Both requesters hold rd valid continuously for 10 messages: grants alternate 0,1,0,1…; neither is granted twice in a row.
- uc_wr at size 0 (1B): beat count clamps to 1; a single data beat, then e_idle.
- Downstream backpressure: `mem_data_ready_i` low for 5 cycles mid-burst. `mem_data_o` stays stable, `beat_cnt` is unchanged, and no beat is lost or duplicated.
- Assert `reset_n_i` low during beat 3 of 8:
  - All `_v_o` and `_ready_o` go to 0 asynchronously.
  - After release: state e_idle, `rr_ptr` = 0, and a fresh rd from req1 completes normally.
